// File: rtl/btb_predictor_if.sv
// IF-stage lookup and ID-stage training bundle between the fetch pipeline and the BTB.
// Master is the pipeline (drives PCs and resolutions); slave is the predictor.
interface btb_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, 1-cycle training, no backpressure.
// Optional saturating stat counters when BTB_STATS_EN is defined.
module btb_predictor #(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 16,
  parameter int JUMP_CNT = 3
) (
  input  logic            clk,
  input  logic            rst,
  btb_predictor_if.slave  bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [1:0] JCNT = 2'(JUMP_CNT);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];
  logic [1:0]       cnt_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_pc_lsbs;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // Gated by rst because valid bits only clear at the end of the reset cycle.
  assign lk_hit = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    bus.pred_taken  = lk_hit && cnt_q[lk_idx][1];
    bus.pred_target = bus.pred_taken ? target_q[lk_idx] : bus.lookup_pc + ADDR_W'(4);
    // Judged against the carried prediction only, so retraining/eviction in between is harmless.
    bus.mispredict  = !rst && bus.upd_en &&
                      ((bus.upd_pred_taken != bus.upd_taken) ||
                       (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (bus.upd_en && !rst) begin
      if (up_hit) begin
        if (bus.upd_is_jump) begin
          cnt_d[up_idx]    = JCNT;
          target_d[up_idx] = bus.upd_target;
        end else if (bus.upd_taken) begin
          cnt_d[up_idx]    = (cnt_q[up_idx] == 2'd3) ? 2'd3 : cnt_q[up_idx] + 2'd1;
          target_d[up_idx] = bus.upd_target;
        end else begin
          cnt_d[up_idx]    = (cnt_q[up_idx] == 2'd0) ? 2'd0 : cnt_q[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bus.upd_target;
        cnt_d[up_idx]    = bus.upd_is_jump ? JCNT : 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: 1'b0};
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    cnt_q    <= cnt_d;
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_lookups_d     = (stat_lookups_q == '1) ? stat_lookups_q : stat_lookups_q + 32'd1;
    stat_hits_d        = stat_hits_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (lk_hit && stat_hits_q != '1) begin
      stat_hits_d = stat_hits_q + 32'd1;
    end
    if (bus.mispredict && stat_mispredicts_q != '1) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_hits_q        <= stat_hits_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_hits        = stat_hits_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Directed-vector bench for btb_predictor (ENTRIES=16, JUMP_CNT=3).
module tb_btb_predictor;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  btb_predictor_if #(.ADDR_W(32)) bus ();

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  btb_predictor #(.ADDR_W(32), .ENTRIES(16), .JUMP_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic jmp, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.upd_en          = en;
    bus.upd_pc          = pc;
    bus.upd_is_jump     = jmp;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
  endtask

  task automatic expect_lookup(input string tag, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tgt);
    bus.lookup_pc = pc;
    #1;
    check({tag, ".taken"},  32'(bus.pred_taken), 32'(tk));
    check({tag, ".target"}, bus.pred_target, tgt);
  endtask

  // Present one update for a single clock edge, checking mispredict while it is applied.
  task automatic train(input string tag, input logic [31:0] pc, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                       input logic exp_mp);
    upd(1'b1, pc, jmp, tk, tgt, ptk, ptgt);
    #1;
    check({tag, ".mispredict"}, 32'(bus.mispredict), 32'(exp_mp));
    tick();
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.lookup_pc = 32'h40;
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // Outputs while reset is held, with a mismatching update presented.
    upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    expect_lookup("in_reset", 32'h40, 1'b0, 32'h44);
    check("in_reset.mispredict", 32'(bus.mispredict), 32'd0);
    tick();
    rst = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    expect_lookup("cold", 32'h40, 1'b0, 32'h44);
    check("cold.mispredict", 32'(bus.mispredict), 32'd0);
    upd(1'b0, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    check("upd_en_low.mispredict", 32'(bus.mispredict), 32'd0);
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Allocate 0x40 while looking it up in the same cycle: old miss now, hit next cycle.
    bus.lookup_pc = 32'h40;
    upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    check("alloc.mispredict", 32'(bus.mispredict), 32'd1);
    check("hazard.taken",  32'(bus.pred_taken), 32'd0);
    check("hazard.target", bus.pred_target, 32'h44);
    tick();
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_lookup("alloc", 32'h40, 1'b1, 32'h80);
    expect_lookup("alias_miss", 32'h80, 1'b0, 32'h84);

    // Hysteresis: cnt 2 -> 1 (not-taken keeps old target) -> 2 -> 3 -> 2.
    train("nt1", 32'h40, 1'b0, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1);
    expect_lookup("cnt1", 32'h40, 1'b0, 32'h44);
    train("t1", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
    expect_lookup("cnt2", 32'h40, 1'b1, 32'h80);
    train("t2", 32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    train("nt2", 32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
    expect_lookup("cnt3_to_2", 32'h40, 1'b1, 32'h80);
    train("newtgt", 32'h40, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1);
    expect_lookup("retarget", 32'h40, 1'b1, 32'h90);

    // Jump at 0x104 (index 1) gets cnt=3: survives one not-taken, falls after a second.
    train("jmp_alloc", 32'h104, 1'b1, 1'b1, 32'h200, 1'b0, 32'h108, 1'b1);
    train("jmp_nt1", 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    expect_lookup("jmp_nt1", 32'h104, 1'b1, 32'h200);
    train("jmp_nt2", 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    expect_lookup("jmp_nt2", 32'h104, 1'b0, 32'h108);
    train("jmp_hit", 32'h104, 1'b1, 1'b1, 32'h400, 1'b0, 32'h108, 1'b1);
    expect_lookup("jmp_hit", 32'h104, 1'b1, 32'h400);

    // Evict 0x40 via aliasing taken update at 0x80.
    train("evict", 32'h80, 1'b0, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1);
    expect_lookup("evicted", 32'h40, 1'b0, 32'h44);
    expect_lookup("evictor", 32'h80, 1'b1, 32'h300);

    // Not-taken miss never allocates; PC+4 wraps at the top of the address space.
    train("nt_miss", 32'h208, 1'b0, 1'b0, 32'h600, 1'b0, 32'h20C, 1'b0);
    expect_lookup("nt_miss", 32'h208, 1'b0, 32'h20C);
    expect_lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Fill more entries, then reset with a concurrent update that must be dropped.
    train("fill3", 32'h10C, 1'b0, 1'b1, 32'h700, 1'b0, 32'h110, 1'b1);
    train("fill4", 32'h110, 1'b1, 1'b1, 32'h800, 1'b0, 32'h114, 1'b1);
    expect_lookup("fill4", 32'h110, 1'b1, 32'h800);
    rst = 1'b1;
    upd(1'b1, 32'h114, 1'b0, 1'b1, 32'h500, 1'b0, 32'h118);
    #1;
    check("mid_reset.mispredict", 32'(bus.mispredict), 32'd0);
    tick();
    rst = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_lookup("post_rst_80",  32'h80,  1'b0, 32'h84);
    expect_lookup("post_rst_104", 32'h104, 1'b0, 32'h108);
    expect_lookup("post_rst_10c", 32'h10C, 1'b0, 32'h110);
    expect_lookup("post_rst_110", 32'h110, 1'b0, 32'h114);
    expect_lookup("post_rst_114", 32'h114, 1'b0, 32'h118);
`ifdef BTB_STATS_EN
    check("stat_lookups", stat_lookups, 32'd0);
    check("stat_hits", stat_hits, 32'd0);
    check("stat_mispredicts", stat_mispredicts, 32'd0);
    tick();
    check("stat_lookups_1", stat_lookups, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the IF stage of the 5-stage pipeline.
- Gives a combinational next-PC prediction for the current fetch PC.
- Is trained by branch/jump resolution in ID.
- Reports mispredicts so the pipeline flushes IF/ID only on a wrong guess, not on every taken branch.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- ENTRIES, 16, table depth; power of two, minimum 2; IDX_W = log2(ENTRIES).
- JUMP_CNT, 3, counter value written for unconditional jumps (2 or 3).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- lookup_pc  in  ADDR_W  IF-stage PC
- pred_taken  out  1  prediction for lookup_pc (combinational)
- pred_target  out  ADDR_W  predicted next PC (combinational)
- upd_en  in  1  resolved branch/jump in ID this cycle; pipeline gates it low while stalled
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_is_jump  in  1  1 = unconditional jump, 0 = conditional branch
- upd_taken  in  1  resolved direction (1 for jumps)
- upd_target  in  ADDR_W  resolved target address
- upd_pred_taken  in  1  prediction made when the instruction was fetched (carried through IF/ID)
- upd_pred_target  in  ADDR_W  predicted target carried through IF/ID
- mispredict  out  1  resolution disagrees with the carried prediction (combinational)

Behaviour:
- Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W], cnt[2]. Index = pc[IDX_W+1:2]; pc[1:0] ignored.
- Lookup (combinational):
  - hit = valid & tag match at index(lookup_pc).
  - pred_taken = hit & cnt[1].
  - pred_target = pred_taken ? entry.target : lookup_pc + 4, modulo 2^ADDR_W (wraps at top of address space).
- Update (registered, posedge clk, when upd_en & ~rst), on the entry at index(upd_pc):
  - Hit, conditional branch: taken → cnt = min(cnt+1, 3); not taken → cnt = max(cnt-1, 0); target replaced by upd_target only when taken.
  - Hit, jump: cnt = JUMP_CNT, target = upd_target.
  - Miss, taken (branch or jump): allocate and overwrite any alias. valid = 1, tag = tag(upd_pc), target = upd_target, cnt = 2 for a branch, JUMP_CNT for a jump.
  - Miss, not taken: no change; not-taken branches are never allocated.
- mispredict = upd_en & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)). It is independent of the current table contents, so it is correct even if the entry was retrained or evicted between fetch and resolution.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents; there is no write-to-read bypass. The new contents are visible on the following cycle.
- Reset:
  - All valid bits are cleared in one cycle; tag, target and cnt need no reset.
  - Outputs while rst = 1: pred_taken = 0, pred_target = lookup_pc + 4, mispredict = 0.
  - An update presented in the reset cycle is dropped.
  - Reset asserted mid-operation discards all training; the first cycle after reset behaves as a cold table.
- No internal state machine beyond per-entry counters; single-cycle throughput; one update per cycle maximum.

Optional Feature:
- Macro BTB_STATS_EN.
- When defined, adds three 32-bit output counters:
  - stat_lookups: +1 every non-reset cycle.
  - stat_hits: +1 when hit.
  - stat_mispredicts: +1 when mispredict.
- Counters saturate at 0xFFFFFFFF and are cleared by rst.
- When undefined, the ports and logic are absent and the interface is exactly as listed above.

Test Plan:
- Cold table: rst 1 cycle, lookup_pc=0x0000_0040 → pred_taken=0, pred_target=0x0000_0044; upd_en=0 → mispredict=0.
- Allocate:
  - Update branch upd_pc=0x40, taken, target=0x80, upd_pred_taken=0 → mispredict=1 that cycle.
  - Next cycle lookup 0x40 → pred_taken=1, pred_target=0x80.
- Hysteresis:
  - Branch entry cnt=2, one not-taken update → lookup 0x40 not taken (cnt=1); two taken updates → taken (cnt=3).
  - Jump entry (JUMP_CNT=3), one not-taken branch update → still taken.
- Alias (ENTRIES=16):
  - 0x40 allocated; lookup 0x80 (same index, different tag) → miss, pred_target=0x84.
  - Taken update at 0x80 evicts 0x40; lookup 0x40 → miss.
- Same-cycle hazard: update allocating 0x40 and lookup 0x40 in the same cycle → old (miss) result that cycle, hit the next cycle.
- Reset mid-run:
  - After training 4 entries, assert rst with upd_en=1 → all lookups miss afterwards and the concurrent update is dropped.
  - With BTB_STATS_EN, all counters read 0.
